// File: rtl/ex_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ex_pipe_pkg
//   Shared definitions for the EX1/EX2 pipeline control logic: the sequencer
//   state encoding, the hard-wired zero register index and the default
//   latency of the custom SAD instruction.
// ----------------------------------------------------------------------------
package ex_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,   // normal flow
        RUN  = 2'b01,   // SAD iterating in EX1
        DONE = 2'b10    // SAD completes this cycle
    } seq_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int SAD_LATENCY_DEF = 4;

endpackage

// File: rtl/ex1_load_use_detect.sv
// ----------------------------------------------------------------------------
// ex1_load_use_detect
//   Purely combinational load-use compare between the load sitting in EX2 and
//   the source registers of the EX1 instruction. Also used by forwarding.
//
//   Ports:
//     valid    in   EX1 holds a real instruction
//     mem_read in   EX2 instruction is a load
//     reg_dst  in   destination register of the EX2 instruction
//     rs, rt   in   source registers of the EX1 instruction
//     hz       out  load-use hazard
// ----------------------------------------------------------------------------
module ex1_load_use_detect
    import ex_pipe_pkg::*;
(
    input  logic       valid,
    input  logic       mem_read,
    input  logic [4:0] reg_dst,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       hz
);

    // $zero is never really written, so a load targeting it cannot create
    // a dependency.
    assign hz = valid & mem_read & (reg_dst != REG_ZERO) &
                ((reg_dst == rs) | (reg_dst == rt));

endmodule

// File: rtl/ex2_stage_sequencer.sv
// ----------------------------------------------------------------------------
// ex2_stage_sequencer
//   Controls the EX1/EX2 pipeline register. Sequences the multi-cycle SAD
//   instruction in EX1 (holding upstream, filling EX2 with bubbles until the
//   result is ready), inserts a one-cycle load-use stall and squashes EX1 on
//   jump/JR flushes.
//
//   Ports:
//     Clk, Reset       clock (rising edge), async active-low reset
//     Valid_EX1        EX1 holds a real instruction
//     CustomOp_EX1     EX1 instruction is the SAD op
//     rs_EX1, rt_EX1   EX1 source registers
//     MemRead_EX2      EX2 instruction is a load
//     RegDst_EX2       EX2 destination register
//     Flush_EX1        jump/JR resolved, EX1 squashed
//     Stall_Upstream   hold PC, IF/ID, ID/EX1
//     EX2_Load         EX1/EX2 register captures
//     EX2_Bubble       EX1/EX2 register captures zeroed control
//     SadBusy          SAD in progress (RUN or DONE)
//     SadDone          pulse: SAD result captured into EX2
//     SadAbort         pulse: SAD killed by a flush
//     IterCount        current SAD iteration index
// ----------------------------------------------------------------------------
module ex2_stage_sequencer
    import ex_pipe_pkg::*;
#(
    parameter int SAD_LATENCY = SAD_LATENCY_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid_EX1,
    input  logic             CustomOp_EX1,
    input  logic [4:0]       rs_EX1,
    input  logic [4:0]       rt_EX1,
    input  logic             MemRead_EX2,
    input  logic [4:0]       RegDst_EX2,
    input  logic             Flush_EX1,
    output logic             Stall_Upstream,
    output logic             EX2_Load,
    output logic             EX2_Bubble,
    output logic             SadBusy,
    output logic             SadDone,
    output logic             SadAbort,
    output logic [CNT_W-1:0] IterCount
);

    generate
        if (SAD_LATENCY < 3 || SAD_LATENCY > 255) begin : g_bad_latency
            $error("ex2_stage_sequencer: SAD_LATENCY out of range 3..255");
        end
        if ((SAD_LATENCY - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
            $error("ex2_stage_sequencer: CNT_W too narrow for SAD_LATENCY-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(SAD_LATENCY - 2);

    seq_state_t       state;
    logic [CNT_W-1:0] iter_cnt;
    logic             hz;
    logic             sad_start;

    ex1_load_use_detect u_hz (
        .valid    (Valid_EX1),
        .mem_read (MemRead_EX2),
        .reg_dst  (RegDst_EX2),
        .rs       (rs_EX1),
        .rt       (rt_EX1),
        .hz       (hz)
    );

    // Flush and the load-use stall both outrank starting a new SAD op.
    assign sad_start = Valid_EX1 & CustomOp_EX1 & ~Flush_EX1 & ~hz;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sad_start) begin
                        state    <= RUN;
                        iter_cnt <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (Flush_EX1) begin
                        state    <= IDLE;
                        iter_cnt <= '0;
                    end else if (iter_cnt == LAST_RUN) begin
                        // Count is held so the DONE cycle still shows it.
                        state <= DONE;
                    end else begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    iter_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    iter_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs are a function of state and inputs; the reset term forces the
    // reset values while Reset is held low regardless of the inputs.
    always_comb begin
        Stall_Upstream = 1'b0;
        EX2_Load       = 1'b1;
        EX2_Bubble     = 1'b0;
        SadBusy        = 1'b0;
        SadDone        = 1'b0;
        SadAbort       = 1'b0;
        if (!Reset) begin
            EX2_Load   = 1'b0;
            EX2_Bubble = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Flush_EX1) begin
                        EX2_Bubble = 1'b1;
                    end else if (hz || (Valid_EX1 && CustomOp_EX1)) begin
                        Stall_Upstream = 1'b1;
                        EX2_Bubble     = 1'b1;
                    end
                end
                RUN: begin
                    SadBusy = 1'b1;
                    if (Flush_EX1) begin
                        EX2_Bubble = 1'b1;
                        SadAbort   = 1'b1;
                    end else begin
                        Stall_Upstream = 1'b1;
                        EX2_Bubble     = 1'b1;
                    end
                end
                DONE: begin
                    SadBusy = 1'b1;
                    if (Flush_EX1) begin
                        EX2_Bubble = 1'b1;
                        SadAbort   = 1'b1;
                    end else begin
                        SadDone = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IterCount = iter_cnt;

endmodule

// File: tb/tb_ex2_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ex2_stage_sequencer
//   Directed bench for ex2_stage_sequencer with SAD_LATENCY=4. Inputs are
//   driven 1 time unit after the rising edge, outputs are checked 1 unit
//   later. Output vector order: {Stall, Load, Bubble, Busy, Done, Abort}.
// ----------------------------------------------------------------------------
module tb_ex2_stage_sequencer;

    localparam int LAT   = 4;
    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Valid_EX1, CustomOp_EX1, MemRead_EX2, Flush_EX1;
    logic [4:0]       rs_EX1, rt_EX1, RegDst_EX2;
    logic             Stall_Upstream, EX2_Load, EX2_Bubble;
    logic             SadBusy, SadDone, SadAbort;
    logic [CNT_W-1:0] IterCount;

    int errors = 0;
    int checks = 0;

    ex2_stage_sequencer #(.SAD_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Valid_EX1      (Valid_EX1),
        .CustomOp_EX1   (CustomOp_EX1),
        .rs_EX1         (rs_EX1),
        .rt_EX1         (rt_EX1),
        .MemRead_EX2    (MemRead_EX2),
        .RegDst_EX2     (RegDst_EX2),
        .Flush_EX1      (Flush_EX1),
        .Stall_Upstream (Stall_Upstream),
        .EX2_Load       (EX2_Load),
        .EX2_Bubble     (EX2_Bubble),
        .SadBusy        (SadBusy),
        .SadDone        (SadDone),
        .SadAbort       (SadAbort),
        .IterCount      (IterCount)
    );

    always #5 Clk = ~Clk;

    // Expected output patterns
    localparam logic [5:0] O_RST   = 6'b001000;
    localparam logic [5:0] O_PASS  = 6'b010000;
    localparam logic [5:0] O_STALL = 6'b111000;
    localparam logic [5:0] O_RUN   = 6'b111100;
    localparam logic [5:0] O_DONE  = 6'b010110;
    localparam logic [5:0] O_FLSH  = 6'b011000;
    localparam logic [5:0] O_ABRT  = 6'b011101;

    task automatic chk(input string tag, input logic [5:0] exp_o,
                       input logic [CNT_W-1:0] exp_c);
        logic [5:0] obs;
        #1;
        obs = {Stall_Upstream, EX2_Load, EX2_Bubble, SadBusy, SadDone, SadAbort};
        checks++;
        assert (obs === exp_o) else begin
            errors++;
            $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp_o);
        end
        checks++;
        assert (IterCount === exp_c) else begin
            errors++;
            $error("FAIL %s IterCount obs=%0d exp=%0d", tag, IterCount, exp_c);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Check the current cycle, then advance to the next one.
    task automatic cyc(input string tag, input logic [5:0] exp_o,
                       input logic [CNT_W-1:0] exp_c);
        chk(tag, exp_o, exp_c);
        tick();
    endtask

    task automatic idle_in();
        Valid_EX1 = 0; CustomOp_EX1 = 0; MemRead_EX2 = 0; Flush_EX1 = 0;
        rs_EX1 = 0; rt_EX1 = 0; RegDst_EX2 = 0;
    endtask

    task automatic sad_in();
        idle_in();
        Valid_EX1 = 1; CustomOp_EX1 = 1; rs_EX1 = 2; rt_EX1 = 3;
    endtask

    initial begin
        // Reset held with a SAD op presented
        Reset = 0;
        sad_in();
        cyc("rst0", O_RST, 0);
        cyc("rst1", O_RST, 0);
        cyc("rst2", O_RST, 0);
        Reset = 1;
        cyc("rel_start", O_STALL, 0);
        idle_in();
        cyc("rel_run1", O_RUN, 1);
        cyc("rel_run2", O_RUN, 2);
        cyc("rel_done", O_DONE, 2);
        cyc("rel_idle", O_PASS, 0);

        // Clean SAD op
        sad_in();
        cyc("sad_c0", O_STALL, 0);
        idle_in();
        cyc("sad_c1", O_RUN, 1);
        cyc("sad_c2", O_RUN, 2);
        cyc("sad_c3", O_DONE, 2);
        cyc("sad_c4", O_PASS, 0);

        // Back-to-back: new op in the cycle after DONE is detected there
        sad_in();
        cyc("b2b_a0", O_STALL, 0);
        cyc("b2b_a1", O_RUN, 1);
        cyc("b2b_a2", O_RUN, 2);
        cyc("b2b_a3", O_DONE, 2);
        cyc("b2b_b0", O_STALL, 0);
        idle_in();
        cyc("b2b_b1", O_RUN, 1);
        cyc("b2b_b2", O_RUN, 2);
        cyc("b2b_b3", O_DONE, 2);

        // Load-use on rs
        idle_in(); Valid_EX1 = 1; MemRead_EX2 = 1; RegDst_EX2 = 8; rs_EX1 = 8; rt_EX1 = 3;
        cyc("hz_rs", O_STALL, 0);
        MemRead_EX2 = 0; RegDst_EX2 = 0;
        cyc("hz_rs_after", O_PASS, 0);
        // Load to $zero never stalls
        MemRead_EX2 = 1; RegDst_EX2 = 0; rs_EX1 = 0;
        cyc("hz_zero", O_PASS, 0);
        // Load-use on rt
        RegDst_EX2 = 9; rs_EX1 = 1; rt_EX1 = 9;
        cyc("hz_rt", O_STALL, 0);
        // No match
        RegDst_EX2 = 10;
        cyc("hz_nomatch", O_PASS, 0);
        // Invalid EX1 never raises HZ nor starts a SAD
        Valid_EX1 = 0; CustomOp_EX1 = 1; RegDst_EX2 = 9;
        cyc("hz_invalid", O_PASS, 0);
        cyc("inv_no_sad", O_PASS, 0);

        // Flush in IDLE beats a pending SAD op
        sad_in(); Flush_EX1 = 1;
        cyc("flush_idle", O_FLSH, 0);
        idle_in();
        cyc("flush_idle_after", O_PASS, 0);

        // Flush in cycle 2 of a SAD op
        sad_in();
        cyc("abrt_c0", O_STALL, 0);
        idle_in();
        cyc("abrt_c1", O_RUN, 1);
        Flush_EX1 = 1;
        cyc("abrt_c2", O_ABRT, 2);
        Flush_EX1 = 0;
        cyc("abrt_c3", O_PASS, 0);

        // Flush in DONE
        sad_in();
        cyc("abrtd_c0", O_STALL, 0);
        idle_in();
        cyc("abrtd_c1", O_RUN, 1);
        cyc("abrtd_c2", O_RUN, 2);
        Flush_EX1 = 1;
        cyc("abrtd_c3", O_ABRT, 2);
        Flush_EX1 = 0;
        cyc("abrtd_c4", O_PASS, 0);

        // Hazard and SAD in the same cycle: hazard first, SAD next cycle
        sad_in(); MemRead_EX2 = 1; RegDst_EX2 = 5; rs_EX1 = 5;
        cyc("hzsad_h", O_STALL, 0);
        MemRead_EX2 = 0; RegDst_EX2 = 0;
        cyc("hzsad_start", O_STALL, 0);
        idle_in();
        cyc("hzsad_r1", O_RUN, 1);
        cyc("hzsad_r2", O_RUN, 2);
        cyc("hzsad_done", O_DONE, 2);
        cyc("hzsad_idle", O_PASS, 0);

        // Asynchronous reset in RUN
        sad_in();
        cyc("arst_c0", O_STALL, 0);
        idle_in();
        chk("arst_run", O_RUN, 1);
        Reset = 0;
        chk("arst_low", O_RST, 0);
        tick();
        Reset = 1;
        cyc("arst_rel", O_PASS, 0);
        cyc("arst_nodone", O_PASS, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound in case anything above stalls.
    initial begin
        #20000;
        $display("FAIL timeout simulation did not finish obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
